// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data cache responder with store buffer
module dcache_responder #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int SB_DEPTH       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core2dcache_req,
    input  logic [31:0] core2dcache_addr,
    input  logic [63:0] core2dcache_data,
    input  logic        core2dcache_data_we,
    input  logic [1:0]  core2dcache_data_size,
    output logic [63:0] dcache2core_data,
    output logic        dcache2core_data_valid,
    output logic        dcache_sb_full,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = 2 + WORD_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int ARR_W   = IDX_W + WORD_W;
    localparam int PTR_W   = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W   = $clog2(SB_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_WAIT_SB,
        S_REFILL_REQ,
        S_REFILL_WAIT
    } state_t;

    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [LINES];

    state_t            state_q, state_d;
    logic [WORD_W-1:0] refill_idx_q, refill_idx_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [1:0]        miss_size_q, miss_size_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [29:0]      sb_addr_q [SB_DEPTH];
    logic [29:0]      sb_addr_d [SB_DEPTH];
    logic [31:0]      sb_data_q [SB_DEPTH];
    logic [31:0]      sb_data_d [SB_DEPTH];
    logic [3:0]       sb_strb_q [SB_DEPTH];
    logic [3:0]       sb_strb_d [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             arr_we;
    logic [ARR_W-1:0] arr_widx;
    logic [31:0]      arr_wdata;
    logic [3:0]       arr_wstrb;
    logic             tag_we;

    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [WORD_W-1:0] req_word, miss_word;
    logic              req_hit, sb_push, sb_pop;
    logic [31:0]       req_word_data, refill_word;
    logic              unused_data;

    function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    size_strb = 4'b0001 << off;
            2'd1:    size_strb = off[1] ? 4'b1100 : 4'b0011;
            default: size_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] size_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    size_lanes = {4{d[7:0]}};
            2'd1:    size_lanes = {2{d[15:0]}};
            default: size_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] w);
        case (size)
            2'd0:    extract = {24'b0, w[{off, 3'b000} +: 8]};
            2'd1:    extract = off[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_tag       = core2dcache_addr[TAG_LSB +: TAG_W];
    assign req_idx       = core2dcache_addr[IDX_LSB +: IDX_W];
    assign req_word      = core2dcache_addr[2 +: WORD_W];
    assign req_hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign req_word_data = data_mem[{req_idx, req_word}];
    assign miss_tag      = miss_addr_q[TAG_LSB +: TAG_W];
    assign miss_idx      = miss_addr_q[IDX_LSB +: IDX_W];
    assign miss_word     = miss_addr_q[2 +: WORD_W];
    // The addressed word may be the one arriving right now, not yet in the array.
    assign refill_word   = (miss_word == refill_idx_q) ? mem_resp_data
                                                       : data_mem[{miss_idx, miss_word}];
    assign unused_data   = ^core2dcache_data[63:32];

    assign dcache2core_data       = {32'b0, rdata_q};
    assign dcache2core_data_valid = rvalid_q;
    assign dcache_sb_full         = (count_q == CNT_W'(SB_DEPTH));

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (state_q == S_REFILL_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {miss_addr_q[31:IDX_LSB], refill_idx_q, 2'b00};
        end else if (state_q != S_REFILL_WAIT && count_q != '0) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {sb_addr_q[rd_ptr_q], 2'b00};
            mem_req_wdata = sb_data_q[rd_ptr_q];
            mem_req_wstrb = sb_strb_q[rd_ptr_q];
        end
    end

    assign sb_pop = mem_req_valid && mem_req_we && mem_req_ready;

    always_comb begin
        state_d      = state_q;
        refill_idx_d = refill_idx_q;
        miss_addr_d  = miss_addr_q;
        miss_size_d  = miss_size_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        valid_d      = valid_q;
        sb_addr_d    = sb_addr_q;
        sb_data_d    = sb_data_q;
        sb_strb_d    = sb_strb_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sb_push      = 1'b0;
        arr_we       = 1'b0;
        arr_widx     = {req_idx, req_word};
        arr_wdata    = size_lanes(core2dcache_data_size, core2dcache_data[31:0]);
        arr_wstrb    = size_strb(core2dcache_data_size, core2dcache_addr[1:0]);
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core2dcache_req && core2dcache_data_we) begin
                    // A store into a full buffer is dropped entirely, cache included.
                    if (!dcache_sb_full) begin
                        sb_push = 1'b1;
                        arr_we  = req_hit;
                    end
                end else if (core2dcache_req) begin
                    if (req_hit) begin
                        rdata_d  = extract(core2dcache_data_size, core2dcache_addr[1:0], req_word_data);
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        miss_addr_d      = core2dcache_addr;
                        miss_size_d      = core2dcache_data_size;
                        refill_idx_d     = '0;
                        valid_d[req_idx] = 1'b0;
                        state_d          = (count_q != '0) ? S_WAIT_SB : S_REFILL_REQ;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            S_WAIT_SB: begin
                if (count_q == '0) state_d = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    arr_we    = 1'b1;
                    arr_widx  = {miss_idx, refill_idx_q};
                    arr_wdata = mem_resp_data;
                    arr_wstrb = 4'b1111;
                    if (refill_idx_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        tag_we            = 1'b1;
                        valid_d[miss_idx] = 1'b1;
                        rdata_d           = extract(miss_size_q, miss_addr_q[1:0], refill_word);
                        rvalid_d          = 1'b1;
                        state_d           = S_RESP;
                    end else begin
                        refill_idx_d = refill_idx_q + 1'b1;
                        state_d      = S_REFILL_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sb_push) begin
            sb_addr_d[wr_ptr_q] = core2dcache_addr[31:2];
            sb_data_d[wr_ptr_q] = size_lanes(core2dcache_data_size, core2dcache_data[31:0]);
            sb_strb_d[wr_ptr_q] = size_strb(core2dcache_data_size, core2dcache_addr[1:0]);
            wr_ptr_d            = ptr_next(wr_ptr_q);
        end
        if (sb_pop) rd_ptr_d = ptr_next(rd_ptr_q);
        count_d = count_q + CNT_W'(sb_push) - CNT_W'(sb_pop);
    end

    always_ff @(posedge clock) begin
        if (arr_we) begin
            for (int b = 0; b < 4; b++) begin
                if (arr_wstrb[b]) data_mem[arr_widx][8*b +: 8] <= arr_wdata[8*b +: 8];
            end
        end
        if (tag_we) tag_mem[miss_idx] <= miss_tag;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            refill_idx_q <= '0;
            miss_addr_q  <= '0;
            miss_size_q  <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
                sb_strb_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            refill_idx_q <= refill_idx_d;
            miss_addr_q  <= miss_addr_d;
            miss_size_q  <= miss_size_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sb_addr_q    <= sb_addr_d;
            sb_data_q    <= sb_data_d;
            sb_strb_q    <= sb_strb_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed self-checking bench for dcache_responder
module tb_dcache_responder;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic        core2dcache_req;
    logic [31:0] core2dcache_addr;
    logic [63:0] core2dcache_data;
    logic        core2dcache_data_we;
    logic [1:0]  core2dcache_data_size;
    logic [63:0] dcache2core_data;
    logic        dcache2core_data_valid;
    logic        dcache_sb_full;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_log [$];
    int          rd_wsnap [$];
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [3:0]  wr_strb_log [$];
    logic        resp_pending = 1'b0;
    logic [31:0] resp_word = 32'h0;
    logic [31:0] cur;

    dcache_responder dut (
        .clock                 (clock),
        .reset                 (reset),
        .core2dcache_req       (core2dcache_req),
        .core2dcache_addr      (core2dcache_addr),
        .core2dcache_data      (core2dcache_data),
        .core2dcache_data_we   (core2dcache_data_we),
        .core2dcache_data_size (core2dcache_data_size),
        .dcache2core_data      (dcache2core_data),
        .dcache2core_data_valid(dcache2core_data_valid),
        .dcache_sb_full        (dcache_sb_full),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_we            (mem_req_we),
        .mem_req_addr          (mem_req_addr),
        .mem_req_wdata         (mem_req_wdata),
        .mem_req_wstrb         (mem_req_wstrb),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_data         (mem_resp_data)
    );

    always #5 clock = ~clock;

    // Zero-wait memory: a read accepted at one posedge returns data for the following posedge.
    always begin
        @(negedge clock);
        #3;
        mem_resp_valid = resp_pending;
        mem_resp_data  = resp_pending ? resp_word : 32'h0;
        resp_pending   = 1'b0;
        if (reset && mem_req_valid && mem_req_ready) begin
            if (mem_req_we) begin
                cur = mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (mem_req_wstrb[b]) cur[8*b +: 8] = mem_req_wdata[8*b +: 8];
                mem_model[mem_req_addr] = cur;
                wr_addr_log.push_back(mem_req_addr);
                wr_data_log.push_back(mem_req_wdata);
                wr_strb_log.push_back(mem_req_wstrb);
            end else begin
                rd_log.push_back(mem_req_addr);
                rd_wsnap.push_back(wr_addr_log.size());
                resp_word    = mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr] : 32'h0;
                resp_pending = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        core2dcache_addr      = a;
        core2dcache_data      = {32'h0, d};
        core2dcache_data_size = sz;
        core2dcache_data_we   = 1'b1;
        core2dcache_req       = 1'b1;
        @(negedge clock);
        core2dcache_req       = 1'b0;
        core2dcache_data_we   = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input int hold,
                           output logic [63:0] d, output int lat, output logic again,
                           output logic hold_ok, output int hold_rd);
        int start;
        start                 = rd_log.size();
        core2dcache_addr      = a;
        core2dcache_data_size = sz;
        core2dcache_data_we   = 1'b0;
        core2dcache_req       = 1'b1;
        lat     = -1;
        d       = '0;
        hold_ok = 1'b1;
        hold_rd = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c <= hold) hold_ok = hold_ok & mem_req_valid & mem_req_we;
            if (c == hold) begin
                hold_rd       = rd_log.size() - start;
                mem_req_ready = 1'b1;
            end
            if (dcache2core_data_valid) begin
                lat = c;
                d   = dcache2core_data;
                break;
            end
        end
        core2dcache_req = 1'b0;
        @(negedge clock);
        again = dcache2core_data_valid;
    endtask

    logic [63:0] d;
    int          lat, hrd, nr;
    logic        again, hok;

    initial begin
        reset                 = 1'b0;
        core2dcache_req       = 1'b0;
        core2dcache_addr      = '0;
        core2dcache_data      = '0;
        core2dcache_data_we   = 1'b0;
        core2dcache_data_size = SZ_W;
        mem_req_ready         = 1'b1;
        mem_model[32'h100] = 32'h11;
        mem_model[32'h104] = 32'h22;
        mem_model[32'h108] = 32'h33;
        mem_model[32'h10C] = 32'h44;

        repeat (3) @(negedge clock);
        chk("rst_data", dcache2core_data, 64'h0);
        chk("rst_valid", dcache2core_data_valid, 1'b0);
        chk("rst_sb_full", dcache_sb_full, 1'b0);
        chk("rst_mem_ctl", {mem_req_valid, mem_req_we, mem_req_wstrb}, 6'h0);
        chk("rst_mem_addr_wdata", {mem_req_addr, mem_req_wdata}, 64'h0);
        reset = 1'b1;
        @(negedge clock);

        // Cold miss refill
        do_load(32'h100, SZ_W, 0, d, lat, again, hok, hrd);
        chk("cold_data", d, 64'h11);
        chk("cold_latency", lat, 9);
        chk("cold_single_pulse", again, 1'b0);
        chk("cold_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("cold_rd_addr", rd_log[i], 64'h100 + 64'(4 * i));

        // Hit
        nr = rd_log.size();
        do_load(32'h108, SZ_W, 0, d, lat, again, hok, hrd);
        chk("hit_data", d, 64'h33);
        chk("hit_latency", lat, 1);
        chk("hit_no_mem_read", rd_log.size() - nr, 0);

        // Byte store hit, write-through, then byte load
        do_store(32'h101, SZ_B, 32'hAB);
        do_load(32'h101, SZ_B, 0, d, lat, again, hok, hrd);
        chk("st_byte_load_data", d, 64'hAB);
        chk("st_byte_load_latency", lat, 1);
        chk("st_wr_count", wr_addr_log.size(), 1);
        chk("st_wr_addr", wr_addr_log[0], 32'h100);
        chk("st_wr_data", wr_data_log[0], 32'hABABABAB);
        chk("st_wr_strb", wr_strb_log[0], 4'b0010);

        // Evict the line, change memory, half load refills fresh data
        do_load(32'h500, SZ_W, 0, d, lat, again, hok, hrd);
        chk("evict_data", d, 64'h0);
        chk("evict_latency", lat, 9);
        mem_model[32'h10C] = 32'hBEEF1234;
        do_load(32'h10E, SZ_H, 0, d, lat, again, hok, hrd);
        chk("half_data", d, 64'hBEEF);
        chk("half_latency", lat, 9);
        do_load(32'h100, SZ_W, 0, d, lat, again, hok, hrd);
        chk("merged_word_data", d, 64'h0000AB11);
        chk("merged_word_latency", lat, 1);

        // Store miss then load miss with memory stalled: refill must wait for the drain
        mem_req_ready = 1'b0;
        do_store(32'h2000, SZ_W, 32'hCAFEF00D);
        nr = rd_log.size();
        do_load(32'h2000, SZ_W, 5, d, lat, again, hok, hrd);
        chk("sbwait_write_pending", hok, 1'b1);
        chk("sbwait_no_read_during_stall", hrd, 0);
        chk("sbwait_data", d, 64'hCAFEF00D);
        chk("sbwait_latency", lat, 15);
        chk("sbwait_rd_count", rd_log.size() - nr, 4);
        chk("sbwait_read_after_write", rd_wsnap[nr], 2);
        chk("sbwait_wr_addr", wr_addr_log[1], 32'h2000);

        // Store buffer fills with memory stalled
        mem_req_ready = 1'b0;
        do_store(32'h3000, SZ_W, 32'h1);
        chk("sb_one_not_full", dcache_sb_full, 1'b0);
        do_store(32'h3004, SZ_W, 32'h2);
        chk("sb_full_set", dcache_sb_full, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clock);
        chk("sb_full_clear", dcache_sb_full, 1'b0);
        repeat (2) @(negedge clock);
        chk("sb_drain_count", wr_addr_log.size(), 4);
        chk("sb_drain0", {wr_addr_log[2], wr_data_log[2]}, {32'h3000, 32'h1});
        chk("sb_drain1", {wr_addr_log[3], wr_data_log[3]}, {32'h3004, 32'h2});
        chk("sb_drain_strb", {wr_strb_log[2], wr_strb_log[3]}, 8'hFF);

        // Reset in the middle of a refill
        core2dcache_addr      = 32'h3000;
        core2dcache_data_size = SZ_W;
        core2dcache_data_we   = 1'b0;
        core2dcache_req       = 1'b1;
        @(negedge clock);
        chk("midrst_refill_req", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, 1'b0, 32'h3000});
        @(negedge clock);
        chk("midrst_refill_wait", mem_req_valid, 1'b0);
        reset           = 1'b0;
        core2dcache_req = 1'b0;
        #1;
        chk("midrst_data", dcache2core_data, 64'h0);
        chk("midrst_flags", {dcache2core_data_valid, dcache_sb_full}, 2'b00);
        chk("midrst_mem_ctl", {mem_req_valid, mem_req_we, mem_req_wstrb}, 6'h0);
        chk("midrst_mem_addr_wdata", {mem_req_addr, mem_req_wdata}, 64'h0);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("postrst_idle", {dcache2core_data_valid, mem_req_valid}, 2'b00);
        nr = rd_log.size();
        do_load(32'h3000, SZ_W, 0, d, lat, again, hok, hrd);
        chk("postrst_data", d, 64'h1);
        chk("postrst_latency", lat, 9);
        chk("postrst_refill_reads", rd_log.size() - nr, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
